// File: rtl/ahb_pt_mem_slave.sv
// AHB-lite single-port 64-bit memory slave for page-table walks and PTE write-backs.
// Programmable OKAY wait states, two-cycle ERROR response, write-to-read forwarding.
module ahb_pt_mem_slave #(
    parameter logic [63:0] BASE       = 64'h0000_0000_8000_0000,
    parameter int          DEPTH_LOG2 = 9,
    parameter int          WAIT       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [63:0] haddr,
    input  logic        hwrite,
    input  logic [3:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic        hmastlock,
    input  logic [63:0] hwdata,
    output logic [63:0] hrdata,
    output logic        hready,
    output logic        hresp
);

    localparam logic [63:0] LIMIT = BASE + (64'd8 << DEPTH_LOG2);
    localparam logic [2:0]  WLAST = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAITS, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [63:0]           hrdata_q, hrdata_d;
    logic [DEPTH_LOG2-1:0] word_q;
    logic [2:0]            lane_q;
    logic [1:0]            size_q;
    logic                  write_q;

    logic [63:0] mem [0:(1<<DEPTH_LOG2)-1];

    logic                  accept;
    logic                  addr_err;
    logic [63:0]           off;
    logic [DEPTH_LOG2-1:0] word_in;
    logic [DEPTH_LOG2-1:0] rd_word;
    logic                  rd_write;
    logic [63:0]           rd_val;
    logic [7:0]            be_q;
    logic                  unused_ok;

    function automatic logic addr_illegal(input logic [63:0] a, input logic [3:0] sz);
        logic bad;
        bad = 1'b0;
        case (sz)
            4'd0:    bad = 1'b0;
            4'd1:    bad = a[0];
            4'd2:    bad = |a[1:0];
            4'd3:    bad = |a[2:0];
            default: bad = 1'b1;
        endcase
        return bad || (a < BASE) || (a >= LIMIT);
    endfunction

    function automatic logic [7:0] byte_en(input logic [1:0] sz, input logic [2:0] lane);
        logic [7:0] m;
        case (sz)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << lane;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                          input logic [7:0] be);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return r;
    endfunction

    assign hready    = (state_q != S_WAITS) && (state_q != S_ERR1);
    assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign hrdata    = hrdata_q;
    assign accept    = hready && hsel && htrans[1];
    assign addr_err  = addr_illegal(haddr, hsize);
    assign off       = haddr - BASE;
    assign word_in   = off[DEPTH_LOG2+2:3];
    assign be_q      = byte_en(size_q, lane_q);
    assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0], off[63:DEPTH_LOG2+3], off[2:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hrdata_d = '0;
        rd_val   = '0;
        rd_word  = accept ? word_in : word_q;
        rd_write = accept ? hwrite : write_q;
        case (state_q)
            S_IDLE, S_DATA, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    cnt_d = 3'd0;
                    if (addr_err)      state_d = S_ERR1;
                    else if (WAIT > 0) state_d = S_WAITS;
                    else               state_d = S_DATA;
                end
            end
            S_WAITS: begin
                if (cnt_q == WLAST) state_d = S_DATA;
                else                cnt_d   = cnt_q + 3'd1;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
        // Read data is captured on entry to DATA; a write committing this cycle to the same word is forwarded.
        if (state_d == S_DATA && !rd_write) begin
            rd_val = mem[rd_word];
            if (state_q == S_DATA && write_q && rd_word == word_q) begin
                rd_val = merge(rd_val, hwdata, be_q);
            end
            hrdata_d = rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hrdata_q <= hrdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            word_q  <= word_in;
            lane_q  <= haddr[2:0];
            size_q  <= hsize[1:0];
            write_q <= hwrite;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == S_DATA && write_q) begin
            mem[word_q] <= merge(mem[word_q], hwdata, be_q);
        end
    end

endmodule
